// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//
// Shares the peripheral register bus between the CPU register port and a
// secondary requester (sprite/DMA loader). The CPU cannot stall, so it always
// owns the bus when it is active; the secondary port is granted only on
// cycles the CPU leaves idle. With GATE_VBLANK set, secondary writes are
// granted only during vertical blank. Read data is routed back to whichever
// port issued the read, using a tag pipeline as deep as the peripheral read
// latency.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_index_i / cpu_read_i / cpu_write_i / cpu_write_value_i
//                                CPU register access (never stalled)
//   cpu_read_value_o             CPU read data; same timing as a direct wire
//   dma_req_i / dma_we_i / dma_index_i / dma_write_value_i
//                                secondary request fields
//   dma_ack_o                    secondary request is on the bus this cycle
//   dma_read_valid_o / dma_read_value_o
//                                one-cycle pulse with secondary read data
//   in_vblank_i                  vertical-blank flag from display controller
//   bus_index_o / bus_read_o / bus_write_o / bus_write_value_o
//                                muxed register bus towards the peripherals
//   bus_read_value_i             read data from the peripheral read mux
//
// Secondary handshake: the requester raises dma_req_i with dma_we_i,
// dma_index_i and dma_write_value_i stable and keeps them so until it sees
// dma_ack_o=1. dma_ack_o is combinational and high on exactly the cycle the
// request is driven onto the bus; the transfer completes on that cycle. The
// requester may change or drop the request on the following cycle, or
// present a new one, so back-to-back acks are possible.

module reg_bus_arbiter #(
  parameter int INDEX_WIDTH  = 7,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,   // legal range 1..4
  parameter bit GATE_VBLANK  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic [INDEX_WIDTH-1:0] cpu_index_i,
  input  logic                   cpu_read_i,
  input  logic                   cpu_write_i,
  input  logic [DATA_WIDTH-1:0]  cpu_write_value_i,
  output logic [DATA_WIDTH-1:0]  cpu_read_value_o,

  input  logic                   dma_req_i,
  input  logic                   dma_we_i,
  input  logic [INDEX_WIDTH-1:0] dma_index_i,
  input  logic [DATA_WIDTH-1:0]  dma_write_value_i,
  output logic                   dma_ack_o,
  output logic                   dma_read_valid_o,
  output logic [DATA_WIDTH-1:0]  dma_read_value_o,

  input  logic                   in_vblank_i,

  output logic [INDEX_WIDTH-1:0] bus_index_o,
  output logic                   bus_read_o,
  output logic                   bus_write_o,
  output logic [DATA_WIDTH-1:0]  bus_write_value_o,
  input  logic [DATA_WIDTH-1:0]  bus_read_value_i
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DMA  = 2'd2
  } tag_e;

  logic cpu_active;
  logic gate_open;
  logic dma_ok;

  assign cpu_active = cpu_read_i | cpu_write_i;
  // Reads are never gated; only writes wait for vblank when gating is on.
  assign gate_open  = ~GATE_VBLANK | in_vblank_i;
  assign dma_ok     = dma_req_i & ~cpu_active & (~dma_we_i | gate_open);
  assign dma_ack_o  = dma_ok;

  // Bus mux: CPU first, then the secondary port, otherwise an idle bus.
  always_comb begin
    bus_index_o       = '0;
    bus_read_o        = 1'b0;
    bus_write_o       = 1'b0;
    bus_write_value_o = '0;
    if (cpu_active) begin
      bus_index_o       = cpu_index_i;
      bus_read_o        = cpu_read_i;
      bus_write_o       = cpu_write_i;
      bus_write_value_o = cpu_write_value_i;
    end else if (dma_ok) begin
      bus_index_o       = dma_index_i;
      bus_read_o        = ~dma_we_i;
      bus_write_o       = dma_we_i;
      bus_write_value_o = dma_write_value_i;
    end
  end

  // Tag pipeline: one entry per cycle, so any number of reads can be in
  // flight. The tail entry names the owner of bus_read_value_i this cycle.
  tag_e tag_q [READ_LATENCY];
  tag_e tag_entry;
  tag_e tag_tail;

  always_comb begin
    tag_entry = TAG_NONE;
    if (cpu_read_i) begin
      tag_entry = TAG_CPU;
    end else if (dma_ok && !dma_we_i) begin
      tag_entry = TAG_DMA;
    end
  end

  assign tag_tail = tag_q[READ_LATENCY-1];

  logic [DATA_WIDTH-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] dma_value_q, dma_value_d;
  logic                  dma_valid_q, dma_valid_d;

  always_comb begin
    cpu_hold_d  = cpu_hold_q;
    dma_value_d = dma_value_q;
    dma_valid_d = 1'b0;
    if (tag_tail == TAG_CPU) begin
      cpu_hold_d = bus_read_value_i;
    end
    if (tag_tail == TAG_DMA) begin
      dma_value_d = bus_read_value_i;
      dma_valid_d = 1'b1;
    end
  end

  // The CPU sees returning data on the same cycle it arrives (as if wired
  // straight to the peripheral mux) and the held copy otherwise.
  assign cpu_read_value_o = (tag_tail == TAG_CPU) ? bus_read_value_i : cpu_hold_q;
  assign dma_read_value_o = dma_value_q;
  assign dma_read_valid_o = dma_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      cpu_hold_q  <= '0;
      dma_value_q <= '0;
      dma_valid_q <= 1'b0;
    end else begin
      tag_q[0] <= tag_entry;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      cpu_hold_q  <= cpu_hold_d;
      dma_value_q <= dma_value_d;
      dma_valid_q <= dma_valid_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter. Two instances (read latency 1 and 3) share
// all request inputs; each has its own peripheral model returning mem[index]
// a fixed latency after a bus read and random data on other cycles.
module tb_reg_bus_arbiter;

  localparam int IW = 7;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- shared stimulus ----------------
  logic [IW-1:0] cpu_index;
  logic          cpu_read, cpu_write;
  logic [DW-1:0] cpu_wv;
  logic          dma_req, dma_we;
  logic [IW-1:0] dma_index;
  logic [DW-1:0] dma_wv;
  logic          in_vblank;

  // ---------------- per-instance outputs ----------------
  logic [DW-1:0] u1_cpu_rv, u1_dval, u1_bwv, rv1;
  logic          u1_ack, u1_dvld, u1_brd, u1_bwr;
  logic [IW-1:0] u1_bidx;
  logic [DW-1:0] u3_cpu_rv, u3_dval, u3_bwv, rv3;
  logic          u3_ack, u3_dvld, u3_brd, u3_bwr;
  logic [IW-1:0] u3_bidx;

  reg_bus_arbiter #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .READ_LATENCY(1), .GATE_VBLANK(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_index_i(cpu_index), .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_write_value_i(cpu_wv), .cpu_read_value_o(u1_cpu_rv),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_index_i(dma_index),
    .dma_write_value_i(dma_wv), .dma_ack_o(u1_ack), .dma_read_valid_o(u1_dvld),
    .dma_read_value_o(u1_dval), .in_vblank_i(in_vblank),
    .bus_index_o(u1_bidx), .bus_read_o(u1_brd), .bus_write_o(u1_bwr),
    .bus_write_value_o(u1_bwv), .bus_read_value_i(rv1)
  );

  reg_bus_arbiter #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .READ_LATENCY(3), .GATE_VBLANK(1'b1)) u3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_index_i(cpu_index), .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_write_value_i(cpu_wv), .cpu_read_value_o(u3_cpu_rv),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_index_i(dma_index),
    .dma_write_value_i(dma_wv), .dma_ack_o(u3_ack), .dma_read_valid_o(u3_dvld),
    .dma_read_value_o(u3_dval), .in_vblank_i(in_vblank),
    .bus_index_o(u3_bidx), .bus_read_o(u3_brd), .bus_write_o(u3_bwr),
    .bus_write_value_o(u3_bwv), .bus_read_value_i(rv3)
  );

  // ---------------- peripheral models ----------------
  logic [DW-1:0] mem [128];
  logic               p1_v   = 1'b0;
  logic [IW-1:0]      p1_idx = '0;
  logic [2:0]         p3_v   = '0;
  logic [2:0][IW-1:0] p3_idx = '0;
  logic [DW-1:0]      noise1 = '0;
  logic [DW-1:0]      noise3 = '0;

  always @(posedge clk) begin
    p1_v   <= u1_brd;
    p1_idx <= u1_bidx;
    p3_v   <= {p3_v[1:0], u3_brd};
    p3_idx <= {p3_idx[1:0], u3_bidx};
    noise1 <= DW'($urandom);
    noise3 <= DW'($urandom);
  end

  assign rv1 = p1_v    ? mem[p1_idx]    : noise1;
  assign rv3 = p3_v[2] ? mem[p3_idx[2]] : noise3;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          is_dma;
    int            cyc;
    logic [DW-1:0] exp;
  } iss_t;
  iss_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ptr1 = 0, ptr3 = 0;
  logic [DW-1:0] chold1 = '0, chold3 = '0, dhold1 = '0, dhold3 = '0;
  logic last_ok = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Retires every issued read that is due at this cycle for one instance and
  // compares the read-return outputs against the expected/held values.
  task automatic check_inst(input string pfx, input int lat,
                            input logic [DW-1:0] cpu_v, input logic dvld,
                            input logic [DW-1:0] dma_v, inout int ptr,
                            inout logic [DW-1:0] chold, inout logic [DW-1:0] dhold);
    int due;
    logic cd, dd;
    logic [DW-1:0] ce, de;
    cd = 1'b0; dd = 1'b0; ce = '0; de = '0;
    while (ptr < exp_q.size()) begin
      due = exp_q[ptr].cyc + lat + (exp_q[ptr].is_dma ? 1 : 0);
      if (due > cyc) break;
      if (exp_q[ptr].is_dma) begin dd = 1'b1; de = exp_q[ptr].exp; end
      else begin cd = 1'b1; ce = exp_q[ptr].exp; end
      ptr++;
    end
    if (cd) chold = ce;
    check({pfx, " cpu_read_value"}, 32'(cpu_v), 32'(chold));
    check({pfx, " dma_read_valid"}, 32'(dvld), 32'(dd));
    if (dd) dhold = de;
    check({pfx, " dma_read_value"}, 32'(dma_v), 32'(dhold));
  endtask

  // One clock cycle: inputs are already applied (posedge+1); checks run at
  // the negedge, then time advances to the next posedge+1.
  task automatic step();
    logic cpu_act, ok;
    logic [24:0] eb;
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      ptr1 = 0; ptr3 = 0;
      chold1 = '0; chold3 = '0; dhold1 = '0; dhold3 = '0;
    end
    cpu_act = cpu_read | cpu_write;
    ok = dma_req & ~cpu_act & (~dma_we | in_vblank);
    eb = cpu_act ? {cpu_index, cpu_read, cpu_write, cpu_wv}
       : ok      ? {dma_index, ~dma_we, dma_we, dma_wv} : '0;
    check("l1 bus", 32'({u1_bidx, u1_brd, u1_bwr, u1_bwv}), 32'(eb));
    check("l3 bus", 32'({u3_bidx, u3_brd, u3_bwr, u3_bwv}), 32'(eb));
    check("l1 ack", 32'(u1_ack), 32'(ok));
    check("l3 ack", 32'(u3_ack), 32'(ok));
    check_inst("l1", 1, u1_cpu_rv, u1_dvld, u1_dval, ptr1, chold1, dhold1);
    check_inst("l3", 3, u3_cpu_rv, u3_dvld, u3_dval, ptr3, chold3, dhold3);
    if (reset_n) begin
      if (cpu_read) exp_q.push_back('{1'b0, cyc, mem[cpu_index]});
      if (ok && !dma_we) exp_q.push_back('{1'b1, cyc, mem[dma_index]});
    end
    last_ok = ok;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    cpu_index = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wv = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_index = '0; dma_wv = '0;
  endtask

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic          cr, cw;
    logic [IW-1:0] ci;
    logic [DW-1:0] cv;
    logic          dr, dwe;
    logic [IW-1:0] di;
    logic [DW-1:0] dv;
    logic          vb;
    logic [IW-1:0] e_idx;
    logic          e_rd, e_wr;
    logic [DW-1:0] e_wv;
    logic          e_ack;
  } vec_t;
  vec_t vecs [8];

  initial begin
    // idle bus
    vecs[0] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 7'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    // collision: CPU write wins over vblank DMA write
    vecs[1] = '{1'b0, 1'b1, 7'h05, 16'h1234, 1'b1, 1'b1, 7'h06, 16'hBEEF, 1'b1, 7'h05, 1'b0, 1'b1, 16'h1234, 1'b0};
    // CPU idle next cycle: DMA write granted
    vecs[2] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b1, 7'h06, 16'hBEEF, 1'b1, 7'h06, 1'b0, 1'b1, 16'hBEEF, 1'b1};
    // DMA write outside vblank: gated
    vecs[3] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b1, 7'h06, 16'hBEEF, 1'b0, 7'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    // DMA read outside vblank: never gated, write value passed through
    vecs[4] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 7'h21, 16'h5555, 1'b0, 7'h21, 1'b1, 1'b0, 16'h5555, 1'b1};
    // CPU read+write same cycle, DMA read waits
    vecs[5] = '{1'b1, 1'b1, 7'h03, 16'h00FF, 1'b1, 1'b0, 7'h22, 16'h0000, 1'b0, 7'h03, 1'b1, 1'b1, 16'h00FF, 1'b0};
    // CPU read at top index, DMA write in vblank waits
    vecs[6] = '{1'b1, 1'b0, 7'h7F, 16'hA5A5, 1'b1, 1'b1, 7'h44, 16'h7777, 1'b1, 7'h7F, 1'b1, 1'b0, 16'hA5A5, 1'b0};
    // no request: DMA fields ignored
    vecs[7] = '{1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 1'b1, 7'h6A, 16'h1357, 1'b1, 7'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    in_vblank = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
    mem[7'h00] = 16'h000A;
    mem[7'h01] = 16'h0001;
    mem[7'h11] = 16'h0011;
    mem[7'h22] = 16'h0022;
    mem[7'h33] = 16'h0033;
    @(posedge clk); #1;
    repeat (3) step();             // reset state checked by the monitor
    reset_n = 1'b1;
    repeat (2) step();

    // CPU-only read, latency 1
    cpu_read = 1'b1; cpu_index = 7'h00;
    step();
    idle();
    check("cpu read 000A return", 32'(u1_cpu_rv), 32'h000A);
    step();
    check("cpu read 000A held", 32'(u1_cpu_rv), 32'h000A);
    check("cpu read no dma pulse", 32'(u1_dvld), 32'h0);
    step();

    // DMA read alone
    dma_req = 1'b1; dma_we = 1'b0; dma_index = 7'h01;
    #1;
    check("dma read ack", 32'(u1_ack), 32'h1);
    check("dma read bus_read", 32'(u1_brd), 32'h1);
    check("dma read bus_index", 32'(u1_bidx), 32'h01);
    step();
    idle();
    step();
    check("dma read valid", 32'(u1_dvld), 32'h1);
    check("dma read value", 32'(u1_dval), 32'h0001);
    step();
    check("dma read pulse one cycle", 32'(u1_dvld), 32'h0);

    // Combinational vector table
    in_vblank = 1'b0;
    for (int v = 0; v < 8; v++) begin
      cpu_read = vecs[v].cr; cpu_write = vecs[v].cw; cpu_index = vecs[v].ci; cpu_wv = vecs[v].cv;
      dma_req = vecs[v].dr; dma_we = vecs[v].dwe; dma_index = vecs[v].di; dma_wv = vecs[v].dv;
      in_vblank = vecs[v].vb;
      #1;
      check($sformatf("vec%0d bus", v), 32'({u1_bidx, u1_brd, u1_bwr, u1_bwv}),
            32'({vecs[v].e_idx, vecs[v].e_rd, vecs[v].e_wr, vecs[v].e_wv}));
      check($sformatf("vec%0d ack", v), 32'(u1_ack), 32'(vecs[v].e_ack));
      step();
    end
    idle(); in_vblank = 1'b0;
    repeat (4) step();

    // Vblank gating of a held DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_index = 7'h09; dma_wv = 16'hCAFE;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("gated write ack", 32'(u1_ack), 32'h0);
      check("gated write bus_write", 32'(u1_bwr), 32'h0);
      step();
    end
    in_vblank = 1'b1;
    #1;
    check("vblank write ack", 32'(u1_ack), 32'h1);
    check("vblank write bus_write", 32'(u1_bwr), 32'h1);
    step();
    idle(); in_vblank = 1'b0;
    step();

    // Interleaved CPU / DMA / CPU reads, latency 3
    cpu_read = 1'b1; cpu_index = 7'h11;
    step();
    idle(); dma_req = 1'b1; dma_we = 1'b0; dma_index = 7'h22;
    step();
    idle(); cpu_read = 1'b1; cpu_index = 7'h33;
    step();
    idle();
    check("l3 interleave cpu first", 32'(u3_cpu_rv), 32'h0011);
    step();
    check("l3 interleave cpu held", 32'(u3_cpu_rv), 32'h0011);
    step();
    check("l3 interleave cpu second", 32'(u3_cpu_rv), 32'h0033);
    check("l3 interleave dma valid", 32'(u3_dvld), 32'h1);
    check("l3 interleave dma value", 32'(u3_dval), 32'h0022);
    repeat (3) step();

    // Reset while a DMA read is in flight
    dma_req = 1'b1; dma_we = 1'b0; dma_index = 7'h40;
    step();
    idle();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("post-reset l1 dma valid", 32'(u1_dvld), 32'h0);
      check("post-reset l3 dma valid", 32'(u3_dvld), 32'h0);
      check("post-reset l1 dma value", 32'(u1_dval), 32'h0);
      check("post-reset l3 dma value", 32'(u3_dval), 32'h0);
      check("post-reset l1 cpu value", 32'(u1_cpu_rv), 32'h0);
      step();
    end

    // Random traffic; the requester keeps its fields until acked
    for (int i = 0; i < 400; i++) begin
      cpu_read  = ($urandom_range(0, 3) == 0);
      cpu_write = ($urandom_range(0, 4) == 0);
      cpu_index = IW'($urandom_range(0, 127));
      cpu_wv    = DW'($urandom);
      in_vblank = ($urandom_range(0, 2) == 0);
      if (!(dma_req && !last_ok)) begin
        dma_req   = ($urandom_range(0, 1) == 1);
        dma_we    = ($urandom_range(0, 1) == 1);
        dma_index = IW'($urandom_range(0, 127));
        dma_wv    = DW'($urandom);
      end
      step();
    end
    idle();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
